frame_deframer: RTL and testbench

FRAME_DEFRAMER -- requirements
Module: frame_deframer

---
 rtl/frame_deframer_pkg.sv | 23 ++
 rtl/frame_deframer_fas_detector.sv | 25 ++
 rtl/frame_deframer.sv | 141 ++++++++++++++
 tb/tb_frame_deframer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_deframer_pkg.sv
// Frame format constants and sync-state encoding, shared by the deframer and the sender mapper.
package frame_deframer_pkg;

  localparam int FRAME_COLS_DEF = 1041;
  localparam int OH_COLS_DEF    = 16;
  localparam int FRAME_ROWS     = 4;
  localparam int FAS_LEN        = 6;
  localparam int ARQ_COL        = 6;

  localparam logic [7:0] FAS_BYTE_A = 8'hF6;
  localparam logic [7:0] FAS_BYTE_B = 8'h28;
  localparam logic [7:0] ARQ_ON     = 8'hFF;
  localparam logic [7:0] ARQ_OFF    = 8'h00;

  localparam logic [8*FAS_LEN-1:0] FAS_WORD = {{3{FAS_BYTE_A}}, {3{FAS_BYTE_B}}};

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } sync_state_t;

endpackage

// File: rtl/frame_deframer_fas_detector.sv
// Sliding frame-alignment window: match is high on the valid byte that completes F6 F6 F6 28 28 28.
module fas_detector
  import frame_deframer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       match
);

  // Only the five previous bytes are stored; the current byte completes the window.
  logic [8*(FAS_LEN-1)-1:0] hist_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg <= '0;
    end else if (valid) begin
      hist_reg <= {hist_reg[8*(FAS_LEN-2)-1:0], data};
    end
  end

  assign match = valid && ({hist_reg, data} == FAS_WORD);

endmodule

// File: rtl/frame_deframer.sv
// Receive deframer: hunts for the FAS, confirms alignment, tracks row/column and forwards payload bytes.
module frame_deframer
  import frame_deframer_pkg::*;
#(
  parameter int FRAME_COLS   = FRAME_COLS_DEF,
  parameter int OH_COLS      = OH_COLS_DEF,
  parameter int SYNC_CONFIRM = 2,
  parameter int LOF_THRESH   = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_line_data,
  input  logic        i_line_data_valid,
  output logic [7:0]  o_pyld_data,
  output logic        o_pyld_data_valid,
  output logic [1:0]  o_row_cnt,
  output logic [10:0] o_col_cnt,
  output logic        o_frame_start,
  output logic        o_in_frame,
  output logic        o_lof,
  output logic        o_arq_en
);

  sync_state_t state_reg;
  logic [10:0] col_reg;
  logic [1:0]  row_reg;
  logic [3:0]  confirm_reg;
  logic [3:0]  err_reg;

  logic        fas_match;
  logic        at_fas;
  logic        at_arq;
  logic        col_last;
  logic        row_last;
  logic        in_pyld;
  logic [10:0] col_next;
  logic [1:0]  row_next;

  fas_detector u_fas (
    .clk   (i_clk),
    .rst_n (i_rst),
    .data  (i_line_data),
    .valid (i_line_data_valid),
    .match (fas_match)
  );

  // row_reg/col_reg give the frame position of the byte currently on i_line_data.
  assign at_fas   = (row_reg == 2'd0) && (col_reg == 11'(FAS_LEN - 1));
  assign at_arq   = (row_reg == 2'd0) && (col_reg == 11'(ARQ_COL));
  assign col_last = (col_reg == 11'(FRAME_COLS - 1));
  assign row_last = (row_reg == 2'(FRAME_ROWS - 1));
  assign in_pyld  = (col_reg >= 11'(OH_COLS)) && (col_reg <= 11'(FRAME_COLS - 2));
  assign col_next = col_last ? 11'd0 : col_reg + 11'd1;
  assign row_next = !col_last ? row_reg : (row_last ? 2'd0 : row_reg + 2'd1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg         <= HUNT;
      col_reg           <= '0;
      row_reg           <= '0;
      confirm_reg       <= '0;
      err_reg           <= '0;
      o_pyld_data       <= '0;
      o_pyld_data_valid <= 1'b0;
      o_row_cnt         <= '0;
      o_col_cnt         <= '0;
      o_frame_start     <= 1'b0;
      o_in_frame        <= 1'b0;
      o_lof             <= 1'b0;
      o_arq_en          <= 1'b0;
    end else begin
      o_frame_start     <= 1'b0;
      o_pyld_data_valid <= 1'b0;
      if (i_line_data_valid) begin
        o_pyld_data       <= i_line_data;
        o_row_cnt         <= row_reg;
        o_col_cnt         <= col_reg;
        o_pyld_data_valid <= (state_reg == SYNC) && in_pyld;

        if (state_reg != HUNT) begin
          col_reg <= col_next;
          row_reg <= row_next;
          if (at_arq && (i_line_data == ARQ_ON)) begin
            o_arq_en <= 1'b1;
          end else if (at_arq && (i_line_data == ARQ_OFF)) begin
            o_arq_en <= 1'b0;
          end
        end

        case (state_reg)
          HUNT: begin
            if (fas_match) begin
              row_reg     <= '0;
              col_reg     <= 11'(FAS_LEN);
              confirm_reg <= 4'd1;
              err_reg     <= '0;
              state_reg   <= PRESYNC;
            end
          end
          PRESYNC: begin
            if (at_fas) begin
              if (!fas_match) begin
                state_reg   <= HUNT;
                row_reg     <= '0;
                col_reg     <= '0;
                confirm_reg <= '0;
              end else if (int'(confirm_reg) + 1 >= SYNC_CONFIRM) begin
                state_reg   <= SYNC;
                o_in_frame  <= 1'b1;
                o_lof       <= 1'b0;
                err_reg     <= '0;
                confirm_reg <= '0;
              end else begin
                confirm_reg <= confirm_reg + 4'd1;
              end
            end
          end
          SYNC: begin
            if (at_fas) begin
              if (fas_match) begin
                err_reg       <= '0;
                o_frame_start <= 1'b1;
              end else if (int'(err_reg) + 1 >= LOF_THRESH) begin
                o_lof      <= 1'b1;
                o_in_frame <= 1'b0;
                state_reg  <= HUNT;
                row_reg    <= '0;
                col_reg    <= '0;
                err_reg    <= '0;
              end else begin
                err_reg <= err_reg + 4'd1;
              end
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_deframer.sv
// Directed bench for frame_deframer: acquisition, payload extraction, LOF, mis-positioned FAS, idle gaps, reset.
module tb_frame_deframer;
  import frame_deframer_pkg::*;

  localparam int FC = 1041;
  localparam int FB = 4 * FC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  line_data;
  logic        line_valid;
  logic [7:0]  pyld_data;
  logic        pyld_valid;
  logic [1:0]  row_cnt;
  logic [10:0] col_cnt;
  logic        frame_start;
  logic        in_frame;
  logic        lof;
  logic        arq_en;

  always #5 clk = ~clk;

  frame_deframer dut (
    .i_clk             (clk),
    .i_rst             (rst_n),
    .i_line_data       (line_data),
    .i_line_data_valid (line_valid),
    .o_pyld_data       (pyld_data),
    .o_pyld_data_valid (pyld_valid),
    .o_row_cnt         (row_cnt),
    .o_col_cnt         (col_cnt),
    .o_frame_start     (frame_start),
    .o_in_frame        (in_frame),
    .o_lof             (lof),
    .o_arq_en          (arq_en)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cur_fid = 0;
  bit gaps_on = 1'b0;

  int n_pv = 0, n_bad = 0, n16 = 0, n1039 = 0, n_badcol = 0, n_fs = 0;
  int n_row[4] = '{default: 0};

  function automatic logic [7:0] pay(input int fid, input int row, input int col);
    return 8'(fid * 5 + row * 3 + col);
  endfunction

  // mode 0: clean frame, 1: FAS corrupted, 2: FAS moved to row 0 cols 20-25
  function automatic logic [7:0] frame_byte(input int fid, input logic [7:0] arq,
                                            input int mode, input int r, input int c);
    if (r == 0 && mode == 2 && c >= 20 && c < 26) return (c < 23) ? FAS_BYTE_A : FAS_BYTE_B;
    if (r == 0 && c < 6) begin
      if (mode == 2) return 8'h00;
      if (mode == 1 && c == 3) return 8'h29;
      return (c < 3) ? FAS_BYTE_A : FAS_BYTE_B;
    end
    if (r == 0 && c == 6) return arq;
    if (c < 16 || c == FC - 1) return 8'h00;
    return pay(fid, r, c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    int n;
    if (gaps_on && $urandom_range(0, 31) == 0) begin
      n = $urandom_range(1, 5);
      repeat (n) begin
        @(negedge clk);
        line_valid = 1'b0;
        line_data  = 8'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    line_data  = b;
    line_valid = 1'b1;
  endtask

  task automatic send(input int fid, input logic [7:0] arq, input int mode,
                      input int from, input int to);
    cur_fid = fid;
    for (int k = from; k < to; k++) put(frame_byte(fid, arq, mode, k / FC, k % FC));
  endtask

  task automatic settle();
    @(negedge clk);
    line_valid = 1'b0;
  endtask

  // Payload monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (pyld_valid === 1'b1) begin
      n_pv++;
      n_row[row_cnt]++;
      if (pyld_data !== pay(cur_fid, int'(row_cnt), int'(col_cnt))) n_bad++;
      else if (col_cnt == 11'd16) n16++;
      else if (col_cnt == 11'd1039) n1039++;
      if (col_cnt < 11'd16 || col_cnt > 11'd1039) n_badcol++;
    end
    if (frame_start === 1'b1) n_fs++;
  end

  initial begin
    int rs[4];
    int s16, s1039, fs0, pv0;

    rst_n      = 1'b0;
    line_data  = 8'h00;
    line_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_frame", in_frame, 0);
    chk("reset_pyld_valid", pyld_valid, 0);
    chk("reset_lof", lof, 0);
    chk("reset_arq", arq_en, 0);
    chk("reset_col", col_cnt, 0);
    rst_n = 1'b1;

    // Random line noise, then clean frames.
    for (int i = 0; i < 500; i++) put(8'($urandom_range(0, 255)));
    settle();
    chk("noise_no_sync", in_frame, 0);
    chk("noise_no_payload", n_pv, 0);

    send(1, ARQ_ON, 0, 0, 6);
    settle();
    chk("fas1_presync_in_frame", in_frame, 0);
    send(1, ARQ_ON, 0, 6, FB);
    settle();
    chk("fas1_arq_set", arq_en, 1);
    chk("presync_no_payload", n_pv, 0);

    gaps_on = 1'b1;
    send(2, ARQ_ON, 0, 0, 6);
    settle();
    chk("fas2_sync", in_frame, 1);
    send(2, ARQ_ON, 0, 6, FB);

    for (int r = 0; r < 4; r++) rs[r] = n_row[r];
    s16 = n16; s1039 = n1039; fs0 = n_fs;
    send(3, ARQ_ON, 0, 0, FB);
    settle();
    for (int r = 0; r < 4; r++) chk($sformatf("row%0d_payload_count", r), n_row[r] - rs[r], 1024);
    chk("col16_match_count", n16 - s16, 4);
    chk("col1039_match_count", n1039 - s1039, 4);
    chk("payload_data_errors", n_bad, 0);
    chk("payload_in_ovh_or_stuff", n_badcol, 0);
    chk("f3_arq", arq_en, 1);
    gaps_on = 1'b0;

    // FAS corruption: two in a row hold sync, three in a row lose frame.
    send(4, ARQ_ON, 1, 0, 6);
    settle();
    chk("one_bad_fas_holds", in_frame, 1);
    send(4, ARQ_ON, 1, 6, FB);
    send(5, ARQ_ON, 1, 0, 6);
    settle();
    chk("two_bad_fas_holds", in_frame, 1);
    chk("two_bad_fas_no_lof", lof, 0);
    send(5, ARQ_ON, 1, 6, FB);
    send(6, ARQ_ON, 0, 0, FB);
    send(7, ARQ_ON, 1, 0, FB);
    send(8, ARQ_ON, 1, 0, 6);
    settle();
    chk("second_two_bad_holds", in_frame, 1);
    send(8, ARQ_ON, 1, 6, FB);
    send(9, ARQ_ON, 1, 0, 6);
    settle();
    chk("three_bad_hunt", in_frame, 0);
    chk("three_bad_lof", lof, 1);
    chk("frame_start_pulses", n_fs - fs0, 2);

    // Second frame with its FAS in the wrong place while in PRESYNC.
    pv0 = n_pv;
    send(10, ARQ_ON, 0, 0, FB);
    send(11, ARQ_ON, 2, 0, FB);
    send(12, ARQ_ON, 0, 0, FB);
    settle();
    chk("wrongpos_not_synced", in_frame, 0);
    chk("wrongpos_no_payload", n_pv - pv0, 0);
    chk("lof_sticky", lof, 1);

    // Re-sync, then reset mid-row.
    gaps_on = 1'b1;
    send(13, ARQ_ON, 0, 0, FB);
    send(14, ARQ_ON, 0, 0, 6);
    settle();
    chk("resync_in_frame", in_frame, 1);
    chk("resync_lof_cleared", lof, 0);
    send(14, ARQ_ON, 0, 6, FB);
    send(15, 8'h5A, 0, 0, 1501);
    settle();
    chk("arq_other_holds", arq_en, 1);
    chk("latency_valid", pyld_valid, 1);
    chk("latency_row", row_cnt, 1);
    chk("latency_col", col_cnt, 459);
    chk("latency_data", pyld_data, pay(15, 1, 459));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", pyld_data, 0);
    chk("async_rst_valid", pyld_valid, 0);
    chk("async_rst_row", row_cnt, 0);
    chk("async_rst_col", col_cnt, 0);
    chk("async_rst_fs", frame_start, 0);
    chk("async_rst_in_frame", in_frame, 0);
    chk("async_rst_lof", lof, 0);
    chk("async_rst_arq", arq_en, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send(16, ARQ_ON, 0, 0, 6);
    settle();
    chk("post_rst_fas1_presync", in_frame, 0);
    send(16, ARQ_ON, 0, 6, FB);
    settle();
    chk("post_rst_arq_ff", arq_en, 1);
    send(17, ARQ_OFF, 0, 0, 6);
    settle();
    chk("post_rst_fas2_sync", in_frame, 1);
    send(17, ARQ_OFF, 0, 6, 7);
    settle();
    chk("arq_00_clears", arq_en, 0);
    chk("final_payload_errors", n_bad, 0);
    chk("final_ovh_stuff_valid", n_badcol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
